// File: rtl/fractal_sync_tx_mc.sv
// Multicast tx stage of the fractal sync tree: splits one wake response into per-channel FIFOs.
// The low NUM_CH dst bits select child channels; the remaining bits travel down shifted.
module fractal_sync_tx_mc #(
  parameter  int unsigned NUM_CH     = 2,
  parameter  int unsigned IN_DST_W   = 8,
  parameter  int unsigned FIFO_DEPTH = 2,
  parameter  int unsigned IN_REG     = 1,
  localparam int unsigned OUT_DST_W  = IN_DST_W - NUM_CH,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rsp_valid_i,
  output logic                          rsp_ready_o,
  input  logic [IN_DST_W-1:0]           rsp_dst_i,
  input  logic                          rsp_error_i,
  output logic [NUM_CH-1:0]             out_valid_o,
  input  logic [NUM_CH-1:0]             out_ready_i,
  output logic [NUM_CH*OUT_DST_W-1:0]   out_dst_o,
  output logic [NUM_CH-1:0]             out_error_o,
  output logic [NUM_CH*CNT_W-1:0]       count_o,
  input  logic                          clear_i,
  output logic                          err_nodst_o,
  output logic [7:0]                    drop_cnt_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("fractal_sync_tx_mc: NUM_CH must be >= 1");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("fractal_sync_tx_mc: FIFO_DEPTH must be >= 1");
  end
  if (IN_DST_W <= NUM_CH) begin : g_bad_dst_w
    $error("fractal_sync_tx_mc: IN_DST_W must be > NUM_CH");
  end

  typedef struct packed {
    logic                 err;
    logic [OUT_DST_W-1:0] dst;
  } entry_t;

  logic [NUM_CH-1:0] has_space;
  logic              stg_valid;
  logic [NUM_CH-1:0] stg_mask;
  entry_t            stg_entry;
  logic              commit;
  logic [NUM_CH-1:0] push;
  logic              drop;

  // Space is judged on registered counts only, so a same-cycle pop never frees room for
  // this cycle's commit; that keeps ready free of any path from out_ready_i.
  assign commit = stg_valid & (&(has_space | ~stg_mask));
  assign push   = commit ? stg_mask : '0;
  assign drop   = commit & (stg_mask == '0);

  if (IN_REG != 0) begin : g_in_reg
    logic              reg_valid;
    logic [NUM_CH-1:0] reg_mask;
    entry_t            reg_entry;
    logic              accept;

    assign rsp_ready_o = rst_ni & (~reg_valid | commit);
    assign accept      = rsp_valid_i & rsp_ready_o;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        reg_valid <= 1'b0;
      end else if (accept) begin
        reg_valid <= 1'b1;
      end else if (commit) begin
        reg_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (accept) begin
        reg_mask  <= rsp_dst_i[NUM_CH-1:0];
        reg_entry <= '{err: rsp_error_i, dst: rsp_dst_i[IN_DST_W-1:NUM_CH]};
      end
    end

    assign stg_valid = reg_valid;
    assign stg_mask  = reg_mask;
    assign stg_entry = reg_entry;
  end else begin : g_no_in_reg
    assign stg_valid   = rsp_valid_i & rst_ni;
    assign stg_mask    = rsp_dst_i[NUM_CH-1:0];
    assign stg_entry   = '{err: rsp_error_i, dst: rsp_dst_i[IN_DST_W-1:NUM_CH]};
    assign rsp_ready_o = rst_ni & (&(has_space | ~rsp_dst_i[NUM_CH-1:0]));
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;

    assign pop          = (count != '0) & out_ready_i[i];
    assign has_space[i] = (count < CNT_FULL);

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) begin
          wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_W'(1);
        end
        case ({push[i], pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // NOTE: the storage array is deliberately not reset; validity is carried entirely by
    // count, so resetting the data would only add reset fan-out to plain RAM bits.
    always_ff @(posedge clk_i) begin
      if (push[i]) begin
        mem[wr_ptr] <= stg_entry;
      end
    end

    assign out_valid_o[i]                         = (count != '0);
    assign out_dst_o[i*OUT_DST_W +: OUT_DST_W]     = mem[rd_ptr].dst;
    assign out_error_o[i]                         = mem[rd_ptr].err;
    assign count_o[i*CNT_W +: CNT_W]              = count;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_nodst_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else if (clear_i) begin
      err_nodst_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else if (drop) begin
      err_nodst_o <= 1'b1;
      if (drop_cnt_o != 8'hFF) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fractal_sync_tx_mc.sv
// Directed bench for fractal_sync_tx_mc: registered-input instance plus an IN_REG=0 instance.
module tb_fractal_sync_tx_mc;

  logic        clk;
  logic        rst_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_dst;
  logic        rsp_error;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [11:0] out_dst;
  logic [1:0]  out_error;
  logic [3:0]  count;
  logic        clear;
  logic        err_nodst;
  logic [7:0]  drop_cnt;

  logic        r0_valid;
  logic        r0_ready;
  logic [7:0]  r0_dst;
  logic [1:0]  r0_out_valid;
  logic [1:0]  r0_out_ready;
  logic [11:0] r0_out_dst;
  logic [1:0]  r0_out_error;
  logic [3:0]  r0_count;
  logic        r0_err_nodst;
  logic [7:0]  r0_drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  fractal_sync_tx_mc #(.NUM_CH(2), .IN_DST_W(8), .FIFO_DEPTH(2), .IN_REG(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_dst_i(rsp_dst), .rsp_error_i(rsp_error),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_dst_o(out_dst), .out_error_o(out_error),
    .count_o(count), .clear_i(clear), .err_nodst_o(err_nodst), .drop_cnt_o(drop_cnt)
  );

  fractal_sync_tx_mc #(.NUM_CH(2), .IN_DST_W(8), .FIFO_DEPTH(2), .IN_REG(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_valid_i(r0_valid), .rsp_ready_o(r0_ready), .rsp_dst_i(r0_dst), .rsp_error_i(1'b1),
    .out_valid_o(r0_out_valid), .out_ready_i(r0_out_ready), .out_dst_o(r0_out_dst),
    .out_error_o(r0_out_error), .count_o(r0_count), .clear_i(1'b0),
    .err_nodst_o(r0_err_nodst), .drop_cnt_o(r0_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_valid = 1'b0; rsp_dst = '0; rsp_error = 1'b0; out_ready = 2'b11; clear = 1'b0;
    r0_valid = 1'b0; r0_dst = '0; r0_out_ready = 2'b11;
    tick(2);
    n_vec++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", rsp_ready); end
    n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", out_valid); end
    n_vec++; if (count !== 4'h0) begin n_err++; $display("FAIL reset_count got %h want 0", count); end
    n_vec++; if ({err_nodst, drop_cnt} !== 9'h0) begin n_err++; $display("FAIL reset_drop got %b/%0d want 0/0", err_nodst, drop_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    rsp_valid = 1'b1; rsp_dst = 8'b0001_0110; rsp_error = 1'b0;
    n_vec++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL uni_ready got %b want 1", rsp_ready); end
    tick();
    rsp_valid = 1'b0;
    n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL uni_lat1 got %b want 00", out_valid); end
    tick();
    n_vec++; if (out_valid !== 2'b10) begin n_err++; $display("FAIL uni_valid got %b want 10", out_valid); end
    n_vec++; if (out_dst[11:6] !== 6'b000101) begin n_err++; $display("FAIL uni_dst got %b want 000101", out_dst[11:6]); end
    n_vec++; if (out_error[1] !== 1'b0) begin n_err++; $display("FAIL uni_err got %b want 0", out_error[1]); end
    tick();
    n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL uni_popped got %b want 00", out_valid); end
  endtask

  task automatic test_multicast();
    out_ready = 2'b00;
    rsp_valid = 1'b1; rsp_dst = 8'hF3; rsp_error = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL mc_valid got %b want 11", out_valid); end
    n_vec++; if (out_dst !== {6'h3C, 6'h3C}) begin n_err++; $display("FAIL mc_dst got %h want %h", out_dst, {6'h3C, 6'h3C}); end
    n_vec++; if (out_error !== 2'b11) begin n_err++; $display("FAIL mc_err got %b want 11", out_error); end
    n_vec++; if (count !== 4'b0101) begin n_err++; $display("FAIL mc_count got %b want 0101", count); end
    out_ready = 2'b11;
    tick();
    n_vec++; if (count !== 4'b0000) begin n_err++; $display("FAIL mc_count_pop got %b want 0000", count); end
  endtask

  task automatic test_backpressure();
    out_ready = 2'b00; rsp_error = 1'b0;
    rsp_valid = 1'b1; rsp_dst = 8'h05; tick();
    rsp_dst = 8'h09; tick();
    rsp_dst = 8'h0D; tick();
    rsp_valid = 1'b0;
    n_vec++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", rsp_ready); end
    tick(3);
    n_vec++; if (count[1:0] !== 2'd2) begin n_err++; $display("FAIL bp_full got %0d want 2", count[1:0]); end
    n_vec++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_hold got %b want 0", rsp_ready); end
    n_vec++; if (out_dst[5:0] !== 6'd1) begin n_err++; $display("FAIL bp_head0 got %0d want 1", out_dst[5:0]); end
    out_ready = 2'b01;
    tick();
    n_vec++; if (count[1:0] !== 2'd1) begin n_err++; $display("FAIL bp_nobypass got %0d want 1", count[1:0]); end
    n_vec++; if (out_dst[5:0] !== 6'd2) begin n_err++; $display("FAIL bp_head1 got %0d want 2", out_dst[5:0]); end
    n_vec++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got %b want 1", rsp_ready); end
    tick();
    n_vec++; if (count[1:0] !== 2'd1) begin n_err++; $display("FAIL bp_pushpop got %0d want 1", count[1:0]); end
    n_vec++; if (out_dst[5:0] !== 6'd3) begin n_err++; $display("FAIL bp_head2 got %0d want 3", out_dst[5:0]); end
    tick();
    n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL bp_drain got %b want 00", out_valid); end
  endtask

  task automatic test_atomic();
    out_ready = 2'b10;
    rsp_valid = 1'b1; rsp_dst = 8'h01; tick();
    rsp_dst = 8'h05; tick();
    rsp_dst = 8'h0E; tick();
    rsp_dst = 8'h0B;
    n_vec++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL at_mask10_ready got %b want 1", rsp_ready); end
    tick();
    rsp_valid = 1'b0;
    n_vec++; if (out_valid !== 2'b11 || out_dst[11:6] !== 6'd3) begin n_err++; $display("FAIL at_mask10 got %b/%0d want 11/3", out_valid, out_dst[11:6]); end
    n_vec++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL at_blocked_ready got %b want 0", rsp_ready); end
    tick(2);
    n_vec++; if (out_valid !== 2'b01) begin n_err++; $display("FAIL at_no_partial got %b want 01", out_valid); end
    out_ready = 2'b11;
    tick(2);
    n_vec++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL at_commit got %b want 11", out_valid); end
    n_vec++; if (out_dst !== {6'd2, 6'd2}) begin n_err++; $display("FAIL at_dst got %h want %h", out_dst, {6'd2, 6'd2}); end
    tick();
    n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL at_drain got %b want 00", out_valid); end
  endtask

  task automatic test_drop();
    rsp_valid = 1'b1; rsp_dst = 8'h40;
    tick(2);
    n_vec++; if (err_nodst !== 1'b1 || drop_cnt !== 8'd1) begin n_err++; $display("FAIL drop_first got %b/%0d want 1/1", err_nodst, drop_cnt); end
    tick(298);
    rsp_valid = 1'b0;
    tick(2);
    n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
    n_vec++; if (out_valid !== 2'b00 || count !== 4'h0) begin n_err++; $display("FAIL drop_nopush got %b/%h want 00/0", out_valid, count); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_vec++; if (err_nodst !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL drop_clear got %b/%0d want 0/0", err_nodst, drop_cnt); end
    rsp_valid = 1'b1; tick();
    clear = 1'b1; rsp_valid = 1'b0; tick();
    clear = 1'b0; tick();
    n_vec++; if (err_nodst !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL drop_clear_prio got %b/%0d want 0/0", err_nodst, drop_cnt); end
  endtask

  task automatic test_mid_reset();
    out_ready = 2'b00;
    rsp_valid = 1'b1; rsp_dst = 8'h07; tick();
    rsp_dst = 8'h0B; tick();
    rsp_valid = 1'b0; tick();
    n_vec++; if (count !== 4'b1010) begin n_err++; $display("FAIL mr_queued got %b want 1010", count); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL mr_ready got %b want 0", rsp_ready); end
    tick();
    n_vec++; if (out_valid !== 2'b00 || count !== 4'h0) begin n_err++; $display("FAIL mr_state got %b/%h want 00/0", out_valid, count); end
    rst_n = 1'b1; out_ready = 2'b11;
    tick();
    n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL mr_after got %b want 00", out_valid); end
  endtask

  task automatic test_no_in_reg();
    r0_valid = 1'b1; r0_dst = 8'b0001_0110;
    #1;
    n_vec++; if (r0_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready got %b want 1", r0_ready); end
    tick();
    r0_valid = 1'b0;
    n_vec++; if (r0_out_valid !== 2'b10) begin n_err++; $display("FAIL r0_lat got %b want 10", r0_out_valid); end
    n_vec++; if (r0_out_dst[11:6] !== 6'b000101 || r0_out_error[1] !== 1'b1) begin n_err++; $display("FAIL r0_data got %b/%b want 000101/1", r0_out_dst[11:6], r0_out_error[1]); end
    tick();
    n_vec++; if (r0_out_valid !== 2'b00 || r0_count !== 4'h0) begin n_err++; $display("FAIL r0_pop got %b/%h want 00/0", r0_out_valid, r0_count); end
    n_vec++; if (r0_err_nodst !== 1'b0 || r0_drop_cnt !== 8'd0) begin n_err++; $display("FAIL r0_drop got %b/%0d want 0/0", r0_err_nodst, r0_drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_atomic();
    test_drop();
    test_mid_reset();
    test_no_in_reg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
